jhash_engine: RTL and testbench
===============================

Name: jhash_engine

Overview:
- Parametrised lookup3 word-hash engine. It implements the full hashword2() flow: length/initval seeding, repeated mix() over 3-word blocks, tail absorption, and the final() avalanche.
- Generalises the existing single-step jhash core with:
  - an internally tracked word count;
  - a programmable seed pair;
  - a real final stage;
  - selectable sub-steps per clock;
  - a dual 32-bit result.
- Sits between the DMA word-stream front end and the flow-table lookup logic.

Parameters:
- LEN_W, 16: width of the word-count input (`len`), in 32-bit words.
- STEPS, 1: mix/final sub-steps evaluated per clock; legal values 1, 2, 3. Mix takes ceil(6/STEPS) cycles; final takes ceil(7/STEPS) cycles.
- MAGIC, 32'hdeadbeef: lookup3 seed constant.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: start pulse; sampled only in IDLE.
- len, in, LEN_W: number of 32-bit key words.
- init_c, in, 32: primary seed (*pc).
- init_b, in, 32: secondary seed (*pb).
- abort, in, 1: synchronous abort; returns the engine to IDLE.
- stream_data0, in, 32: key word k[0] of the current block.
- stream_data1, in, 32: key word k[1] of the current block.
- stream_data2, in, 32: key word k[2] of the current block.
- stream_valid, in, 1: the three stream words are valid.
- stream_ack, out, 1: block accepted (combinational; asserted only in LOAD while stream_valid=1).
- busy, out, 1: state is not IDLE.
- hash_c, out, 32: result c (primary hash).
- hash_b, out, 32: result b (secondary hash).
- hash_valid, out, 1: one-cycle pulse marking the result valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; a, b, c, remaining count, hash_c, hash_b and hash_valid all cleared to 0; busy=0.
- All arithmetic is modulo 2^32.
- rot(x,k) = (x<<k)|(x>>(32-k)).
- States: IDLE, LOAD, MIX, FINAL, DONE.
- IDLE:
  - On start=1: a=b=c=MAGIC+(len<<2)+init_c. The shift is zero-extended and truncated to 32 bits.
  - Then c += init_b, and remaining=len.
  - If len==0, next state is DONE; otherwise LOAD.
- LOAD: stream_ack = stream_valid.
  - On acceptance with remaining>3: a+=d0, b+=d1, c+=d2; remaining-=3; go to MIX.
  - On acceptance with remaining<=3: add only the first `remaining` words (1: a; 2: a,b; 3: a,b,c); go to FINAL.
  - Unused tail words are ignored.
- MIX: the six lookup3 mix sub-steps, in order:
  - a-=c; a^=rot(c,4); c+=b
  - b-=a; b^=rot(a,6); a+=c
  - c-=b; c^=rot(b,8); b+=a
  - a-=c; a^=rot(c,16); c+=b
  - b-=a; b^=rot(a,19); a+=c
  - c-=b; c^=rot(b,4); b+=a
  - STEPS consecutive sub-steps are chained combinationally per clock. The step counter resets on entry.
  - After the last sub-step, go to LOAD.
- FINAL: the seven final sub-steps, in order, with the same STEPS chaining. The last cycle may execute fewer sub-steps.
  - c^=b; c-=rot(b,14)
  - a^=c; a-=rot(c,11)
  - b^=a; b-=rot(a,25)
  - c^=b; c-=rot(b,16)
  - a^=c; a-=rot(c,4)
  - b^=a; b-=rot(a,14)
  - c^=b; c-=rot(b,24)
  - Then go to DONE.
- DONE (one cycle):
  - hash_c<=c and hash_b<=b are registered on entry.
  - hash_valid=1 for exactly this cycle.
  - Next state is IDLE.
  - hash_c and hash_b hold until the next DONE.
- Latency from start edge to hash_valid, for STEPS=1:
  - len 0: 1 cycle.
  - len 1..3: 1 + 1 + 7 = 9 cycles, with stream_valid held high.
  - Each additional 3-word block adds 1 + 6 cycles.
  - Stream stalls (stream_valid=0 in LOAD) add cycles 1:1.
- Boundary conditions:
  - start while busy is ignored.
  - start and stream_valid in the same IDLE cycle: no ack, and no word is consumed.
  - len an exact multiple of 3: the last block goes to FINAL, not MIX (remaining==3).
  - len at its maximum (2^LEN_W-1): the count never wraps, and len<<2 truncates to 32 bits.
  - abort=1 in any state: next state is IDLE, hash_valid stays 0, stream_ack is forced to 0, and hash_c/hash_b keep their old values.
  - abort has priority over start in IDLE.
  - rst_n low mid-hash: immediate return to reset values; no hash_valid pulse.

Test Plan:
- len=0, init_c=0, init_b=0, start -> hash_valid 1 cycle later; hash_c=hash_b=32'hdeadbeef.
- len=0, init_c=1, init_b=0 -> hash_c=32'hdeadbef0, hash_b=32'hdeadbef0.
- len=3, init_c=0, words 1,2,3, STEPS=1 -> exactly one stream_ack; hash_valid 9 cycles after start; hash_c/hash_b match the C hashword2() model.
- len=7 (3 blocks, tail=1), random words and seeds, STEPS in {1,2,3} -> three acks; the result matches the model for every STEPS value; latency follows the ceil() cycle counts.
- len=6 with stream_valid toggling 0/1 and a start pulse injected mid-run -> the start is ignored, no extra acks, and the result equals the model.
- abort in MIX, then rst_n low in FINAL on a second run -> no hash_valid pulse; prior hash_c is retained after abort; all outputs are 0 after reset; busy=0.

Source files
------------

// File: rtl/jhash_engine.sv
// jhash_engine -- lookup3 hashword2() engine.
//
// Seeds a/b/c from the word count and the seed pair, absorbs the key three
// words at a time from the stream interface (mix between blocks), folds in
// the tail block, runs the final() avalanche and presents the c/b pair.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               begin a hash; sampled only in IDLE
//   len                 key length in 32-bit words
//   init_c, init_b      seed pair (*pc, *pb)
//   abort               synchronous abort back to IDLE
//   stream_data0..2     key words k[0..2] of the current block
//   stream_valid        stream words valid
//   stream_ack          block accepted this cycle (combinational)
//   busy                engine not in IDLE
//   hash_c, hash_b      result pair, held until the next completed hash
//   hash_valid          one-cycle result strobe
module jhash_engine #(
    parameter int          LEN_W = 16,
    parameter int          STEPS = 1,
    parameter logic [31:0] MAGIC = 32'hdeadbeef
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      init_c,
    input  logic [31:0]      init_b,
    input  logic             abort,
    input  logic [31:0]      stream_data0,
    input  logic [31:0]      stream_data1,
    input  logic [31:0]      stream_data2,
    input  logic             stream_valid,
    output logic             stream_ack,
    output logic             busy,
    output logic [31:0]      hash_c,
    output logic [31:0]      hash_b,
    output logic             hash_valid
);

    typedef enum logic [2:0] {IDLE, LOAD, MIX, FINAL, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } abc_t;

    localparam logic [LEN_W-1:0] THREE = LEN_W'(3);

    function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // One mix() sub-step; indices past the last sub-step leave the state alone
    // so a partially filled final clock needs no extra guard.
    function automatic abc_t mix_step(input logic [3:0] idx, input abc_t v);
        abc_t r;
        r = v;
        case (idx)
            4'd0: begin r.a = r.a - r.c; r.a = r.a ^ rot(r.c, 4);  r.c = r.c + r.b; end
            4'd1: begin r.b = r.b - r.a; r.b = r.b ^ rot(r.a, 6);  r.a = r.a + r.c; end
            4'd2: begin r.c = r.c - r.b; r.c = r.c ^ rot(r.b, 8);  r.b = r.b + r.a; end
            4'd3: begin r.a = r.a - r.c; r.a = r.a ^ rot(r.c, 16); r.c = r.c + r.b; end
            4'd4: begin r.b = r.b - r.a; r.b = r.b ^ rot(r.a, 19); r.a = r.a + r.c; end
            4'd5: begin r.c = r.c - r.b; r.c = r.c ^ rot(r.b, 4);  r.b = r.b + r.a; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic abc_t final_step(input logic [3:0] idx, input abc_t v);
        abc_t r;
        r = v;
        case (idx)
            4'd0: begin r.c = r.c ^ r.b; r.c = r.c - rot(r.b, 14); end
            4'd1: begin r.a = r.a ^ r.c; r.a = r.a - rot(r.c, 11); end
            4'd2: begin r.b = r.b ^ r.a; r.b = r.b - rot(r.a, 25); end
            4'd3: begin r.c = r.c ^ r.b; r.c = r.c - rot(r.b, 16); end
            4'd4: begin r.a = r.a ^ r.c; r.a = r.a - rot(r.c, 4);  end
            4'd5: begin r.b = r.b ^ r.a; r.b = r.b - rot(r.a, 14); end
            4'd6: begin r.c = r.c ^ r.b; r.c = r.c - rot(r.b, 24); end
            default: ;
        endcase
        return r;
    endfunction

    state_t           state, state_nxt;
    abc_t             abc, abc_nxt, abc_step;
    logic [LEN_W-1:0] remaining, rem_nxt;
    logic [2:0]       step_cnt, cnt_nxt;
    logic [3:0]       step_end;
    logic             load_hash;
    logic [31:0]      seed;

    // len*4 is zero-extended then truncated to 32 bits before seeding.
    assign seed     = MAGIC + (32'(len) << 2) + init_c;
    assign step_end = 4'(step_cnt) + 4'(STEPS);
    assign busy     = (state != IDLE);

    // STEPS sub-steps chained combinationally from the current step index.
    always_comb begin
        abc_step = abc;
        for (int s = 0; s < STEPS; s++) begin
            if (state == MIX) abc_step = mix_step(4'(step_cnt) + 4'(s), abc_step);
            else              abc_step = final_step(4'(step_cnt) + 4'(s), abc_step);
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_nxt  = state;
        abc_nxt    = abc;
        rem_nxt    = remaining;
        cnt_nxt    = step_cnt;
        load_hash  = 1'b0;
        stream_ack = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    abc_nxt = '{a: seed, b: seed, c: seed + init_b};
                    rem_nxt = len;
                    if (len == '0) begin
                        state_nxt = DONE;
                        load_hash = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                stream_ack = stream_valid;
                if (stream_valid) begin
                    cnt_nxt   = '0;
                    abc_nxt.a = abc.a + stream_data0;
                    if (remaining > THREE) begin
                        abc_nxt.b = abc.b + stream_data1;
                        abc_nxt.c = abc.c + stream_data2;
                        rem_nxt   = remaining - THREE;
                        state_nxt = MIX;
                    end else begin
                        // Tail block: only the first `remaining` words count.
                        if (remaining >= LEN_W'(2)) abc_nxt.b = abc.b + stream_data1;
                        if (remaining == THREE)     abc_nxt.c = abc.c + stream_data2;
                        state_nxt = FINAL;
                    end
                end
            end
            MIX: begin
                abc_nxt = abc_step;
                cnt_nxt = step_end[2:0];
                if (step_end >= 4'd6) state_nxt = LOAD;
            end
            FINAL: begin
                abc_nxt = abc_step;
                cnt_nxt = step_end[2:0];
                if (step_end >= 4'd7) begin
                    state_nxt = DONE;
                    load_hash = 1'b1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Abort wins over everything, including start in IDLE.
        if (abort) begin
            state_nxt  = IDLE;
            abc_nxt    = abc;
            rem_nxt    = remaining;
            cnt_nxt    = step_cnt;
            load_hash  = 1'b0;
            stream_ack = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc        <= '0;
            remaining  <= '0;
            step_cnt   <= '0;
            hash_c     <= '0;
            hash_b     <= '0;
            hash_valid <= 1'b0;
        end else begin
            abc        <= abc_nxt;
            remaining  <= rem_nxt;
            step_cnt   <= cnt_nxt;
            hash_valid <= load_hash;
            if (load_hash) begin
                hash_c <= abc_nxt.c;
                hash_b <= abc_nxt.b;
            end
        end
    end

endmodule

// File: tb/tb_jhash_engine.sv
// tb_jhash_engine -- self-checking bench for jhash_engine.
//
// Three engines with STEPS = 1, 2, 3 share clock and reset; each has its own
// stimulus signals. Results are compared against a plain hashword2() model,
// latencies against the ceil() cycle formula.
module tb_jhash_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_s        [3];
    logic [15:0] len_s          [3];
    logic [31:0] init_c_s       [3];
    logic [31:0] init_b_s       [3];
    logic        abort_s        [3];
    logic [31:0] d0_s           [3];
    logic [31:0] d1_s           [3];
    logic [31:0] d2_s           [3];
    logic        stream_valid_s [3];
    logic        stream_ack_s   [3];
    logic        busy_s         [3];
    logic [31:0] hash_c_s       [3];
    logic [31:0] hash_b_s       [3];
    logic        hash_valid_s   [3];

    logic [31:0] key [0:63];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        jhash_engine #(.LEN_W(16), .STEPS(g + 1)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_s[g]),
            .len          (len_s[g]),
            .init_c       (init_c_s[g]),
            .init_b       (init_b_s[g]),
            .abort        (abort_s[g]),
            .stream_data0 (d0_s[g]),
            .stream_data1 (d1_s[g]),
            .stream_data2 (d2_s[g]),
            .stream_valid (stream_valid_s[g]),
            .stream_ack   (stream_ack_s[g]),
            .busy         (busy_s[g]),
            .hash_c       (hash_c_s[g]),
            .hash_b       (hash_b_s[g]),
            .hash_valid   (hash_valid_s[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    // Straight transcription of lookup3 hashword2() over key[0 .. n-1].
    function automatic void jhash_ref(input int n, input logic [31:0] pc, input logic [31:0] pb,
                                      output logic [31:0] hc, output logic [31:0] hb);
        logic [31:0] a, b, c;
        int i, r;
        a = 32'hdeadbeef + (32'(n) << 2) + pc;
        b = a;
        c = a + pb;
        i = 0;
        r = n;
        while (r > 3) begin
            a += key[i]; b += key[i+1]; c += key[i+2];
            a -= c; a ^= rotl(c, 4);  c += b;
            b -= a; b ^= rotl(a, 6);  a += c;
            c -= b; c ^= rotl(b, 8);  b += a;
            a -= c; a ^= rotl(c, 16); c += b;
            b -= a; b ^= rotl(a, 19); a += c;
            c -= b; c ^= rotl(b, 4);  b += a;
            r -= 3;
            i += 3;
        end
        if (r > 0) begin
            if (r >= 3) c += key[i+2];
            if (r >= 2) b += key[i+1];
            a += key[i];
            c ^= b; c -= rotl(b, 14);
            a ^= c; a -= rotl(c, 11);
            b ^= a; b -= rotl(a, 25);
            c ^= b; c -= rotl(b, 16);
            a ^= c; a -= rotl(c, 4);
            b ^= a; b -= rotl(a, 14);
            c ^= b; c -= rotl(b, 24);
        end
        hc = c;
        hb = b;
    endfunction

    function automatic int exp_latency(input int n, input int steps);
        if (n == 0) return 1;
        return 1 + ((n - 1) / 3) * (1 + (6 + steps - 1) / steps) + 1 + (7 + steps - 1) / steps;
    endfunction

    // Runs one hash on engine `inst`; cyc counts clock edges from the edge
    // that sampled start up to the one that raised hash_valid.
    task automatic run_hash(input int inst, input int n, input logic [31:0] pc, input logic [31:0] pb,
                            input bit stall, input bit inj,
                            output int cyc, output int acks, output bit got);
        int blk;
        got  = 1'b0;
        acks = 0;
        @(negedge clk);
        len_s[inst]          = 16'(n);
        init_c_s[inst]       = pc;
        init_b_s[inst]       = pb;
        start_s[inst]        = 1'b1;
        stream_valid_s[inst] = 1'b1;
        d0_s[inst]           = key[0];
        d1_s[inst]           = key[1];
        d2_s[inst]           = key[2];
        #1;
        check($sformatf("ack_in_idle[%0d]", inst), 32'(stream_ack_s[inst]), 32'd0);
        @(negedge clk);
        start_s[inst] = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (hash_valid_s[inst]) begin
                got = 1'b1;
                break;
            end
            if (inj && cyc == 5) begin
                start_s[inst] = 1'b1;
                len_s[inst]   = 16'(n + 3);
            end else begin
                start_s[inst] = 1'b0;
            end
            blk = (acks * 3 + 2 < 64) ? acks * 3 : 0;
            d0_s[inst] = key[blk];
            d1_s[inst] = key[blk+1];
            d2_s[inst] = key[blk+2];
            stream_valid_s[inst] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stream_ack_s[inst]) acks++;
            @(negedge clk);
            cyc++;
        end
        start_s[inst]        = 1'b0;
        stream_valid_s[inst] = 1'b0;
        if (!got) check($sformatf("timeout[%0d]", inst), 32'd0, 32'd1);
    endtask

    task automatic do_hash(input int inst, input int n, input logic [31:0] pc, input logic [31:0] pb,
                           input bit stall, input bit inj);
        int cyc, acks;
        bit got;
        logic [31:0] ec, eb;
        string t;
        t = $sformatf("s%0d_len%0d", inst + 1, n);
        run_hash(inst, n, pc, pb, stall, inj, cyc, acks, got);
        jhash_ref(n, pc, pb, ec, eb);
        check({t, "_hash_c"}, hash_c_s[inst], ec);
        check({t, "_hash_b"}, hash_b_s[inst], eb);
        check({t, "_acks"}, 32'(acks), 32'((n + 2) / 3));
        if (!stall) check({t, "_latency"}, 32'(cyc), 32'(exp_latency(n, inst + 1)));
        @(negedge clk);
        check({t, "_valid_pulse_len"}, 32'(hash_valid_s[inst]), 32'd0);
    endtask

    task automatic fill_key_random();
        for (int i = 0; i < 64; i++) key[i] = $urandom;
    endtask

    initial begin
        logic [31:0] prev_c, prev_b;
        int cyc, acks, seen;
        bit got;

        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; len_s[i] = '0; init_c_s[i] = '0; init_b_s[i] = '0;
            abort_s[i] = 1'b0; d0_s[i] = '0; d1_s[i] = '0; d2_s[i] = '0;
            stream_valid_s[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) key[i] = '0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy[%0d]", i),   32'(busy_s[i]), 32'd0);
            check($sformatf("rst_valid[%0d]", i),  32'(hash_valid_s[i]), 32'd0);
            check($sformatf("rst_hash_c[%0d]", i), hash_c_s[i], 32'd0);
            check($sformatf("rst_hash_b[%0d]", i), hash_b_s[i], 32'd0);
        end
        rst_n = 1'b1;

        // Zero-length keys: seed only, no final().
        run_hash(0, 0, 32'd0, 32'd0, 1'b0, 1'b0, cyc, acks, got);
        check("len0_hash_c", hash_c_s[0], 32'hdeadbeef);
        check("len0_hash_b", hash_b_s[0], 32'hdeadbeef);
        check("len0_latency", 32'(cyc), 32'd1);
        check("len0_acks", 32'(acks), 32'd0);
        run_hash(0, 0, 32'd1, 32'd0, 1'b0, 1'b0, cyc, acks, got);
        check("len0_pc1_hash_c", hash_c_s[0], 32'hdeadbef0);
        check("len0_pc1_hash_b", hash_b_s[0], 32'hdeadbef0);

        // One exact block of three goes straight to FINAL.
        key[0] = 32'd1; key[1] = 32'd2; key[2] = 32'd3;
        do_hash(0, 3, 32'd0, 32'd0, 1'b0, 1'b0);

        // len=7 on every STEPS value.
        for (int i = 0; i < 3; i++) begin
            fill_key_random();
            do_hash(i, 7, $urandom, $urandom, 1'b0, 1'b0);
        end

        // len=6 with stalls and a start pulse injected mid-run.
        for (int i = 0; i < 3; i++) begin
            fill_key_random();
            do_hash(i, 6, $urandom, $urandom, 1'b1, 1'b1);
        end

        // Random lengths, with and without stalls.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) begin
                fill_key_random();
                do_hash(i, $urandom_range(1, 20), $urandom, $urandom, 1'(r & 1), 1'b0);
            end
        end

        // Abort in LOAD with data offered: no ack, back to IDLE.
        prev_c = hash_c_s[0];
        prev_b = hash_b_s[0];
        @(negedge clk);
        len_s[0] = 16'd7; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; stream_valid_s[0] = 1'b1; abort_s[0] = 1'b1;
        #1;
        check("abort_load_ack", 32'(stream_ack_s[0]), 32'd0);
        @(negedge clk);
        abort_s[0] = 1'b0; stream_valid_s[0] = 1'b0;
        check("abort_load_busy", 32'(busy_s[0]), 32'd0);

        // Abort in MIX.
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; stream_valid_s[0] = 1'b1;
        #1;
        check("abort_mix_first_ack", 32'(stream_ack_s[0]), 32'd1);
        @(negedge clk);
        stream_valid_s[0] = 1'b0; abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_mix_busy", 32'(busy_s[0]), 32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (hash_valid_s[0]) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);
        check("abort_keep_hash_c", hash_c_s[0], prev_c);
        check("abort_keep_hash_b", hash_b_s[0], prev_b);

        // Reset asserted while in FINAL.
        key[0] = 32'h11; key[1] = 32'h22; key[2] = 32'h33;
        seen = 0;
        @(negedge clk);
        len_s[0] = 16'd3; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0; stream_valid_s[0] = 1'b1;
        d0_s[0] = key[0]; d1_s[0] = key[1]; d2_s[0] = key[2];
        repeat (3) begin
            @(negedge clk);
            stream_valid_s[0] = 1'b0;
            if (hash_valid_s[0]) seen++;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy_s[0]), 32'd0);
        check("rst_mid_hash_c", hash_c_s[0], 32'd0);
        check("rst_mid_hash_b", hash_b_s[0], 32'd0);
        check("rst_mid_valid", 32'(hash_valid_s[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (hash_valid_s[0]) seen++;
        end
        check("rst_mid_no_valid", 32'(seen), 32'd0);
        check("rst_mid_idle", 32'(busy_s[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
